// File: rtl/tinyalu_cmd_seq.sv
// tinyalu_cmd_seq
//   Queues operand/opcode commands in a small FIFO and runs them one at a
//   time through a tinyalu core, returning one response per command in the
//   order the commands were accepted.
//
// Build option:
//   TINYALU_CMD_SEQ_TIMEOUT_EN - when defined, EXEC gives up after
//   TIMEOUT_CYCLES cycles without alu_done and answers with rsp_err=1.
//   When undefined, EXEC waits for alu_done indefinitely.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready = FIFO not full)
//   cmd_A, cmd_B, cmd_op     command operands and opcode
//   alu_A, alu_B, alu_op     operands/opcode to tinyalu (zero outside EXEC)
//   alu_start, alu_done      tinyalu handshake
//   alu_result               tinyalu result
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_op       captured result and opcode of the answered command
//   rsp_err                  illegal opcode or timeout
//
// state | meaning
// IDLE  | waiting for a queued command; pops the FIFO head
// EXEC  | alu_start held, waiting for alu_done (or timeout)
// RESP  | response presented, waiting for rsp_ready
module tinyalu_cmd_seq #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_A,
  input  logic [7:0]  cmd_B,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("tinyalu_cmd_seq: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  // command FIFO
  logic [18:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;
  logic [18:0]   head;
  logic [7:0]    head_a, head_b;
  logic [2:0]    head_op;
  logic          head_exec;

  // held command for the ALU
  logic [7:0] op_a, op_b;
  logic [2:0] op_q;

  logic cap_done, tmo_hit, tmo_fire;

  // Ready depends only on stored occupancy, so a same-cycle pop never
  // opens a slot for a push when full.
  assign cmd_ready  = (count != CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid & cmd_ready;

  assign head      = fifo_mem[rd_ptr];
  assign head_a    = head[18:11];
  assign head_b    = head[10:3];
  assign head_op   = head[2:0];
  assign head_exec = (head_op != OP_NOP) && (head_op <= OP_MUL);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_A, cmd_B, cmd_op};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef TINYALU_CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Zero on every cycle outside EXEC, so it starts from zero on entry.
  always_ff @(posedge clk) begin
    if (!reset_n)           tmo_cnt <= '0;
    else if (state != EXEC) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TW'(1);
  end

  // This EXEC cycle is the TIMEOUT_CYCLES-th one.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_done  = 1'b0;
    tmo_fire  = 1'b0;
    alu_start = 1'b0;
    alu_A     = '0;
    alu_B     = '0;
    alu_op    = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_exec ? EXEC : RESP;
        end
      end
      EXEC: begin
        alu_start = 1'b1;
        alu_A     = op_a;
        alu_B     = op_b;
        alu_op    = op_q;
        if (alu_done) begin
          cap_done  = 1'b1;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_q       <= '0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        op_a   <= head_a;
        op_b   <= head_b;
        op_q   <= head_op;
        rsp_op <= head_op;
        // no_op and illegal opcodes are answered without touching the ALU
        if (!head_exec) begin
          rsp_result <= '0;
          rsp_err    <= (head_op != OP_NOP);
        end
      end
      if (cap_done) begin
        rsp_result <= alu_result;
        rsp_err    <= 1'b0;
      end
      if (tmo_fire) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_seq.sv
module tb_tinyalu_cmd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_A, cmd_B;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tinyalu_cmd_seq #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_A      (cmd_A),
    .cmd_B      (cmd_B),
    .cmd_op     (cmd_op),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err)
  );

  // Simple tinyalu stand-in: 1-cycle ops, 3-cycle multiply, one-cycle done pulse.
  logic        model_en    = 1'b1;
  logic        inject_done = 1'b0;
  logic        model_done  = 1'b0;
  logic [15:0] model_result = '0;
  int          model_cnt   = 0;

  assign alu_done   = model_done | inject_done;
  assign alu_result = model_result;

  function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (model_en && alu_start && !model_done) begin
      if (model_cnt + 1 >= ((alu_op == 3'b100) ? 3 : 1)) begin
        model_done   <= 1'b1;
        model_result <= alu_calc(alu_A, alu_B, alu_op);
        model_cnt    <= 0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end else begin
      model_done <= 1'b0;
      model_cnt  <= 0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    cmd_A = a; cmd_B = b; cmd_op = op; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, counting cycles with alu_start high.
  task automatic wait_rsp(output bit got, output int starts);
    got = 1'b0;
    starts = 0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (alu_start) starts++;
      @(negedge clk);
    end
  endtask

  logic [7:0]  va [6];
  logic [7:0]  vb [6];
  logic [2:0]  vo [6];
  logic [15:0] ve [5];
  bit got, will;
  int starts, acc, idx, seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_op = '0; rsp_ready = 1'b1;
    va[0] = 8'h01; vb[0] = 8'h02; vo[0] = 3'b001; ve[0] = 16'h0003;
    va[1] = 8'h03; vb[1] = 8'h03; vo[1] = 3'b100; ve[1] = 16'h0009;
    va[2] = 8'h0F; vb[2] = 8'h0F; vo[2] = 3'b010; ve[2] = 16'h000F;
    va[3] = 8'hAA; vb[3] = 8'h55; vo[3] = 3'b011; ve[3] = 16'h00FF;
    va[4] = 8'h10; vb[4] = 8'h10; vo[4] = 3'b100; ve[4] = 16'h0100;
    va[5] = 8'h77; vb[5] = 8'h77; vo[5] = 3'b001;

    // reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // add FF+01 with cycle-exact latency
    cmd_A = 8'hFF; cmd_B = 8'h01; cmd_op = 3'b001; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("lat_start_t", alu_start, 0);
    @(negedge clk);
    chk("lat_start_t1", alu_start, 1);
    chk("lat_alu_A", alu_A, 16'h00FF);
    chk("lat_alu_B", alu_B, 16'h0001);
    chk("lat_alu_op", alu_op, 3'b001);
    @(negedge clk);
    chk("lat_rsp_early", rsp_valid, 0);
    chk("lat_start_t2", alu_start, 1);
    @(negedge clk);
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 16'h0100);
    chk("add_op", rsp_op, 3'b001);
    chk("add_err", rsp_err, 0);
    chk("add_start_off", alu_start, 0);
    @(negedge clk);
    chk("add_rsp_done", rsp_valid, 0);
    chk("idle_alu_A", alu_A, 0);
    chk("idle_alu_op", alu_op, 0);

    // mul FF*FF with response back-pressure
    rsp_ready = 1'b0;
    push_cmd(8'hFF, 8'hFF, 3'b100);
    wait_rsp(got, starts);
    chk("mul_got", got, 1);
    chk("mul_start_cycles", starts, 4);
    chk("mul_result", rsp_result, 16'hFE01);
    chk("mul_err", rsp_err, 0);
    chk("mul_op", rsp_op, 3'b100);
    repeat (2) begin
      @(negedge clk);
      chk("mul_hold_valid", rsp_valid, 1);
      chk("mul_hold_result", rsp_result, 16'hFE01);
      chk("mul_hold_op", rsp_op, 3'b100);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mul_released", rsp_valid, 0);

    // illegal opcode
    push_cmd(8'h12, 8'h34, 3'b110);
    wait_rsp(got, starts);
    chk("ill_got", got, 1);
    chk("ill_starts", starts, 0);
    chk("ill_result", rsp_result, 0);
    chk("ill_err", rsp_err, 1);
    chk("ill_op", rsp_op, 3'b110);

    // no_op
    push_cmd(8'h12, 8'h34, 3'b000);
    wait_rsp(got, starts);
    chk("nop_got", got, 1);
    chk("nop_starts", starts, 0);
    chk("nop_result", rsp_result, 0);
    chk("nop_err", rsp_err, 0);

    // and / xor
    push_cmd(8'hF0, 8'h3C, 3'b010);
    wait_rsp(got, starts);
    chk("and_got", got, 1);
    chk("and_result", rsp_result, 16'h0030);
    chk("and_starts", starts, 2);
    push_cmd(8'hF0, 8'h3C, 3'b011);
    wait_rsp(got, starts);
    chk("xor_got", got, 1);
    chk("xor_result", rsp_result, 16'h00CC);
    chk("xor_err", rsp_err, 0);

    // alu_done while idle is ignored
    @(negedge clk);
    @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    chk("stray_done_valid", rsp_valid, 0);
    @(negedge clk);
    chk("stray_done_valid2", rsp_valid, 0);
    chk("stray_done_start", alu_start, 0);

    // fill FIFO under back-pressure: 5 accepted, then not ready
    rsp_ready = 1'b0;
    acc = 0; idx = 0;
    @(negedge clk);
    cmd_A = va[0]; cmd_B = vb[0]; cmd_op = vo[0]; cmd_valid = 1'b1;
    repeat (12) begin
      will = cmd_ready;
      @(negedge clk);
      if (will) begin
        acc++;
        if (idx < 5) idx++;
        cmd_A = va[idx]; cmd_B = vb[idx]; cmd_op = vo[idx];
      end
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", acc, 5);
    chk("fill_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(got, starts);
      chk("drain_got", got, 1);
      chk("drain_result", rsp_result, ve[k]);
      chk("drain_op", rsp_op, vo[k]);
      @(negedge clk);
    end
    chk("drain_cmd_ready", cmd_ready, 1);
    chk("drain_empty_valid", rsp_valid, 0);

    // reset during mul EXEC with two commands queued
    @(negedge clk);
    cmd_A = 8'hFF; cmd_B = 8'hFF; cmd_op = 3'b100; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_A = 8'h01; cmd_B = 8'h01; cmd_op = 3'b001;
    @(negedge clk);
    cmd_A = 8'h02; cmd_B = 8'h02; cmd_op = 3'b001;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_start", alu_start, 1);
    chk("pre_rst_op", alu_op, 3'b100);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_rst_start", alu_start, 0);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_ready", cmd_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || alu_start) seen++;
    end
    chk("post_rst_no_rsp", seen, 0);

`ifdef TINYALU_CMD_SEQ_TIMEOUT_EN
    // timeout: alu never answers
    model_en = 1'b0;
    push_cmd(8'hFF, 8'h01, 3'b001);
    wait_rsp(got, starts);
    chk("tmo_got", got, 1);
    chk("tmo_start_cycles", starts, 16);
    chk("tmo_start_off", alu_start, 0);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_result", rsp_result, 0);
    model_en = 1'b1;
    @(negedge clk);
`else
    // no timeout: EXEC waits until alu_done finally arrives
    model_en = 1'b0;
    push_cmd(8'h05, 8'h07, 3'b001);
    repeat (30) @(negedge clk);
    chk("wait_no_rsp", rsp_valid, 0);
    chk("wait_start_held", alu_start, 1);
    model_en = 1'b1;
    wait_rsp(got, starts);
    chk("wait_got", got, 1);
    chk("wait_result", rsp_result, 16'h000C);
    chk("wait_err", rsp_err, 0);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyalu_cmd_seq.md
TINYALU_CMD_SEQ -- requirements
Module: tinyalu_cmd_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set command FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the ALU done-wait limit in clk cycles (used only under REQ-031).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  command FIFO not full.
REQ-007 cmd_A, cmd_B  input  8 each  operands.
REQ-008 cmd_op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101-111 illegal.
REQ-009 alu_A, alu_B  output  8 each  operands to tinyalu A/B.
REQ-010 alu_op  output  3  opcode to tinyalu op.
REQ-011 alu_start  output  1  tinyalu start.
REQ-012 alu_done  input  1  tinyalu done.
REQ-013 alu_result  input  16  tinyalu result.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  downstream accepts response.
REQ-016 rsp_result  output  16  captured result.
REQ-017 rsp_op  output  3  opcode of the command answered.
REQ-018 rsp_err  output  1  illegal opcode or timeout.

Function
REQ-019 Push SHALL occur on an edge with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 whenever the FIFO holds FIFO_DEPTH entries, even if a pop occurs in the same cycle.
REQ-020 FSM SHALL have states IDLE, EXEC, RESP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into the operand/op registers; legal non-no_op goes to EXEC, and no_op or illegal goes directly to RESP.
REQ-022 EXEC: alu_start SHALL be 1 and alu_A/alu_B/alu_op SHALL be stable for the whole state.
REQ-023 EXEC: on the first edge sampling alu_done=1, the block SHALL capture alu_result into rsp_result, set rsp_err=0, go to RESP, and drive alu_start=0 from that edge.
REQ-024 no_op SHALL give rsp_result=0 and rsp_err=0; illegal op SHALL give rsp_result=0 and rsp_err=1; neither SHALL assert alu_start.
REQ-025 RESP: rsp_valid SHALL be 1 and rsp_result/rsp_op/rsp_err SHALL be stable until the edge with rsp_ready=1; that edge SHALL return the FSM to IDLE with rsp_valid=0.
REQ-026 One command SHALL be in flight at a time, and responses SHALL follow command order.
REQ-027 alu_done sampled outside EXEC SHALL be ignored.
REQ-028 Latency: with the FIFO empty and rsp_ready=1, a command pushed at edge t SHALL be popped at t+1, with alu_start=1 from t+1; rsp_valid SHALL rise on the edge sampling alu_done=1.
REQ-029 alu_A, alu_B and alu_op SHALL be 0 in IDLE; tinyalu's own op-based multiplexing is not relied on outside EXEC.

Reset
REQ-030 reset_n=0 at an edge SHALL empty the FIFO, set FSM to IDLE, and zero alu_start, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_op and rsp_err; cmd_ready SHALL be 1 from the first edge with reset_n=1. An in-flight command (EXEC or RESP) SHALL be discarded with no response.

Configuration
REQ-031 Macro TINYALU_CMD_SEQ_TIMEOUT_EN defined: a counter SHALL clear on EXEC entry and increment each EXEC cycle. If it reaches TIMEOUT_CYCLES without alu_done, the FSM SHALL go to RESP with rsp_result=0, rsp_err=1 and alu_start=0.
REQ-032 Macro undefined: no counter SHALL exist, and EXEC SHALL wait indefinitely for alu_done.

Verification
REQ-033 add: A=8'hFF, B=8'h01, op=001 -> one response, rsp_result=16'h0100, rsp_err=0, rsp_op=001.
REQ-034 mul: A=8'hFF, B=8'hFF, op=100 -> alu_start held through the 3-cycle multiply, then rsp_result=16'hFE01, rsp_err=0.
REQ-035 op=110, A=8'h12, B=8'h34 -> alu_start never 1, rsp_result=0, rsp_err=1; and op=000 -> rsp_result=0, rsp_err=0.
REQ-036 rsp_ready=0 with continuous cmd_valid -> exactly FIFO_DEPTH+1 (5) commands accepted, then cmd_ready=0; after releasing rsp_ready, responses appear in push order with correct results.
REQ-037 TINYALU_CMD_SEQ_TIMEOUT_EN defined, alu_done forced 0, add issued -> after 16 EXEC cycles alu_start=0, rsp_err=1, rsp_result=0.
REQ-038 reset_n=0 for one edge during a mul EXEC with 2 commands queued -> alu_start=0, rsp_valid=0 and cmd_ready=1 after release; no response appears for the discarded commands.
